// File: rtl/deserializador.sv
// Serial-to-parallel receiver: hunts for a 4-bit sync pattern,
// then assembles back-to-back ANCHO-bit words with ack handshake.
module deserializador #(
    parameter int         ANCHO   = 8,
    parameter logic [3:0] SINC    = 4'b1011,
    parameter int         MAXIDLE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             s_in,
    input  logic             dir,
    input  logic             ack,
    output logic [ANCHO-1:0] q,
    output logic             valido,
    output logic             sincronizado,
    output logic             desborde
);

    localparam int CW = $clog2(ANCHO);

    typedef enum logic {
        BUSCAR,
        RECIBIR
    } estado_t;

    estado_t          estado;
    estado_t          estado_sig;
    logic [3:0]       h;
    logic [CW-1:0]    cnt;
    logic [7:0]       idle;
    logic [ANCHO-1:0] asm_r;
    logic [ANCHO-1:0] asm_sig;
    logic             sinc_ok;
    logic             fin_palabra;
    logic             perdida;

    always_comb begin
        asm_sig     = dir ? {s_in, asm_r[ANCHO-1:1]}
                          : {asm_r[ANCHO-2:0], s_in};
        sinc_ok     = enb && ({h[2:0], s_in} == SINC);
        fin_palabra = (estado == RECIBIR) && enb
                      && (cnt == CW'(ANCHO - 1));
        perdida     = (estado == RECIBIR) && !enb
                      && (idle == 8'(MAXIDLE - 1));
        estado_sig  = estado;
        case (estado)
            BUSCAR:  if (sinc_ok) estado_sig = RECIBIR;
            RECIBIR: if (perdida) estado_sig = BUSCAR;
            default: estado_sig = BUSCAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) estado <= BUSCAR;
        else     estado <= estado_sig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h        <= '0;
            cnt      <= '0;
            idle     <= '0;
            asm_r    <= '0;
            q        <= '0;
            valido   <= 1'b0;
            desborde <= 1'b0;
        end else begin
            case (estado)
                BUSCAR: begin
                    idle <= '0;
                    if (enb) begin
                        h <= {h[2:0], s_in};
                        if (sinc_ok) begin
                            cnt   <= '0;
                            asm_r <= '0;
                        end
                    end
                end
                default: begin
                    if (enb) begin
                        idle  <= '0;
                        asm_r <= asm_sig;
                        cnt   <= fin_palabra ? '0 : cnt + CW'(1);
                    end else if (perdida) begin
                        // sync lost: drop the partial word, restart the hunt
                        idle  <= '0;
                        h     <= '0;
                        cnt   <= '0;
                        asm_r <= '0;
                    end else begin
                        idle <= idle + 8'd1;
                    end
                end
            endcase

            if (fin_palabra) begin
                if (!valido || ack) begin
                    q      <= asm_sig;
                    valido <= 1'b1;
                end else begin
                    desborde <= 1'b1;
                end
            end else if (ack && valido) begin
                valido <= 1'b0;
            end
        end
    end

    assign sincronizado = (estado == RECIBIR);

endmodule

// File: tb/tb_deserializador.sv
// Bench for deserializador: directed scenarios plus a random
// stream checked against an arithmetic reference model.
module tb_deserializador;

    localparam int ANCHO   = 8;
    localparam int SINC    = 4'b1011;
    localparam int MAXIDLE = 16;

    logic             clk = 1'b0;
    logic             rst, enb, s_in, dir, ack;
    logic [ANCHO-1:0] q;
    logic             valido, sincronizado, desborde;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit m_sync;
    int m_hist[$];
    int m_cnt, m_idle, m_w, m_q;
    bit m_v, m_ovf;

    deserializador #(
        .ANCHO  (ANCHO),
        .SINC   (4'(SINC)),
        .MAXIDLE(MAXIDLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .s_in        (s_in),
        .dir         (dir),
        .ack         (ack),
        .q           (q),
        .valido      (valido),
        .sincronizado(sincronizado),
        .desborde    (desborde)
    );

    always #5 clk = ~clk;

    function automatic void model(bit r, bit e, bit s, bit a, bit d);
        bit done = 0;
        int pat;
        if (r) begin
            m_sync = 0; m_hist.delete(); m_cnt = 0; m_idle = 0;
            m_w = 0; m_q = 0; m_v = 0; m_ovf = 0;
            return;
        end
        if (!m_sync) begin
            m_idle = 0;
            if (e) begin
                m_hist.push_back(int'(s));
                if (m_hist.size() > 4) void'(m_hist.pop_front());
                pat = 0;
                foreach (m_hist[i]) pat = pat * 2 + m_hist[i];
                if (m_hist.size() == 4 && pat == SINC) begin
                    m_sync = 1; m_cnt = 0; m_w = 0;
                end
            end
        end else if (e) begin
            m_idle = 0;
            if (d) m_w = (m_w / 2) + int'(s) * (1 << (ANCHO - 1));
            else   m_w = (m_w * 2 + int'(s)) % (1 << ANCHO);
            m_cnt++;
            if (m_cnt == ANCHO) begin
                done = 1;
                m_cnt = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == MAXIDLE) begin
                m_sync = 0; m_hist.delete(); m_cnt = 0;
                m_w = 0; m_idle = 0;
            end
        end
        if (done) begin
            if (!m_v || a) begin
                m_q = m_w; m_v = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (a && m_v) begin
            m_v = 0;
        end
    endfunction

    task automatic cycle(bit r, bit e, bit s, bit a, bit d);
        rst = r; enb = e; s_in = s; ack = a; dir = d;
        @(posedge clk);
        model(r, e, s, a, d);
        #1;
    endtask

    task automatic send(logic [15:0] v, int n, bit d, bit ack_last);
        for (int i = n - 1; i >= 0; i--)
            cycle(0, 1, v[i], (i == 0) && ack_last, d);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++)
            cycle(1, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom));
        checks++;
        if ({q, valido, sincronizado, desborde} !== '0) begin
            errors++;
            $display("FAIL reset: q=%h v=%b s=%b d=%b want all 0",
                     q, valido, sincronizado, desborde);
        end
    endtask

    task automatic test_word(bit d, logic [7:0] exp);
        cycle(1, 0, 0, 0, d);
        send(16'b1011, 4, d, 0);
        checks++;
        if (sincronizado !== 1'b1) begin
            errors++;
            $display("FAIL sync_dir%0d: sincronizado=%b want 1",
                     d, sincronizado);
        end
        send(16'b11001010, 8, d, 0);
        checks++;
        if (valido !== 1'b1 || q !== exp) begin
            errors++;
            $display("FAIL word_dir%0d: q=%h v=%b want q=%h v=1",
                     d, q, valido, exp);
        end
    endtask

    task automatic test_overrun;
        cycle(1, 0, 0, 0, 0);
        send(16'b1011, 4, 0, 0);
        send(16'h3C, 8, 0, 0);
        send(16'hA5, 8, 0, 0);
        checks++;
        if (q !== 8'h3C || valido !== 1'b1 || desborde !== 1'b1) begin
            errors++;
            $display("FAIL overrun: q=%h v=%b d=%b want 3c 1 1",
                     q, valido, desborde);
        end
        cycle(0, 0, 0, 1, 0);
        checks++;
        if (valido !== 1'b0 || desborde !== 1'b1) begin
            errors++;
            $display("FAIL overrun_ack: v=%b d=%b want 0 1",
                     valido, desborde);
        end
    endtask

    task automatic test_back_to_back;
        cycle(1, 0, 0, 0, 0);
        send(16'b1011, 4, 0, 0);
        send(16'h96, 8, 0, 0);
        checks++;
        if (q !== 8'h96 || valido !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: q=%h v=%b want 96 1", q, valido);
        end
        send(16'h5A, 8, 0, 1);
        checks++;
        if (q !== 8'h5A || valido !== 1'b1 || desborde !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ack: q=%h v=%b d=%b want 5a 1 0",
                     q, valido, desborde);
        end
    endtask

    task automatic test_idle;
        cycle(1, 0, 0, 0, 0);
        send(16'b1011, 4, 0, 0);
        send(16'b101, 3, 0, 0);
        for (int i = 0; i < MAXIDLE - 1; i++) cycle(0, 0, 0, 0, 0);
        checks++;
        if (sincronizado !== 1'b1) begin
            errors++;
            $display("FAIL idle_15: sincronizado=%b want 1",
                     sincronizado);
        end
        cycle(0, 0, 0, 0, 0);
        checks++;
        if (sincronizado !== 1'b0 || valido !== 1'b0) begin
            errors++;
            $display("FAIL idle_16: sinc=%b v=%b want 0 0",
                     sincronizado, valido);
        end
        send(16'b1011, 4, 0, 0);
        send(16'b11010, 5, 0, 0);
        checks++;
        if (sincronizado !== 1'b1) begin
            errors++;
            $display("FAIL resync: sincronizado=%b want 1",
                     sincronizado);
        end
        cycle(1, 1, 1, 1, 0);
        checks++;
        if ({q, valido, sincronizado, desborde} !== '0) begin
            errors++;
            $display("FAIL midword_rst: q=%h v=%b s=%b d=%b want 0",
                     q, valido, sincronizado, desborde);
        end
        send(16'b110, 3, 0, 0);
        checks++;
        if (sincronizado !== 1'b0 || valido !== 1'b0) begin
            errors++;
            $display("FAIL post_rst: sinc=%b v=%b want 0 0",
                     sincronizado, valido);
        end
    endtask

    task automatic test_random;
        bit r, e, s, a, d;
        int gap = 0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if (gap == 0 && $urandom_range(0, 99) == 0)
                gap = $urandom_range(10, 20);
            r = ($urandom_range(0, 499) == 0);
            e = (gap > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (gap > 0) gap--;
            s = 1'($urandom);
            a = ($urandom_range(0, 15) == 0);
            d = ($urandom_range(0, 31) == 0) ? ~dir : dir;
            cycle(r, e, s, a, d);
            checks++;
            if (q !== ANCHO'(m_q) || valido !== m_v
                || sincronizado !== m_sync || desborde !== m_ovf) begin
                errors++;
                $display("FAIL random[%0d]: q=%h v=%b s=%b d=%b want %h %b %b %b",
                         i, q, valido, sincronizado, desborde,
                         ANCHO'(m_q), m_v, m_sync, m_ovf);
            end
        end
    endtask

    initial begin
        rst = 1; enb = 0; s_in = 0; dir = 0; ack = 0;
        test_reset;
        test_word(0, 8'hCA);
        test_word(1, 8'h53);
        test_overrun;
        test_back_to_back;
        test_idle;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
